// File: rtl/vproc_fifo.sv
// Synchronous FIFO for vector-processor queues. Non-power-of-two depth,
// optional zero-latency fall-through when empty, flush and almost-full flag.
module vproc_fifo #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned PASS_THROUGH = 0,
  parameter int unsigned AF_THRESH    = DEPTH - 1
) (
  input  logic                       clk_i,
  input  logic                       async_rst_ni,
  input  logic                       flush_i,
  output logic                       enq_ready_o,
  input  logic                       enq_valid_i,
  input  logic [WIDTH-1:0]           enq_data_i,
  input  logic                       deq_ready_i,
  output logic                       deq_valid_o,
  output logic [WIDTH-1:0]           deq_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("vproc_fifo: DEPTH must be at least 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
      $error("vproc_fifo: AF_THRESH must lie in 1..DEPTH");
    end
  endgenerate

  // Pointers wrap explicitly so any DEPTH works, not only powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_PTR) begin
      r = {PTR_W{1'b0}};
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             af_r;

  logic             empty_s;
  logic             full_s;
  logic             bypass_s;
  logic             enq_fire_s;
  logic             deq_fire_s;
  logic             push_s;
  logic             pop_s;
  logic             deq_valid_s;
  logic [WIDTH-1:0] deq_data_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;

  // Handshake decode; a bypassed word that is consumed the same cycle is never stored.
  always_comb begin
    empty_s     = (count_r == {CNT_W{1'b0}});
    full_s      = (count_r == DEPTH_C);
    bypass_s    = 1'b0;
    deq_valid_s = 1'b0;
    deq_data_s  = mem_r[rd_ptr_r];
    if ((PASS_THROUGH != 0) && empty_s) begin
      bypass_s    = 1'b1;
      deq_valid_s = enq_valid_i;
      deq_data_s  = enq_data_i;
    end else begin
      deq_valid_s = !empty_s;
    end
    enq_fire_s = enq_valid_i && !full_s;
    deq_fire_s = deq_valid_s && deq_ready_i;
    if (bypass_s) begin
      push_s = enq_fire_s && !deq_ready_i;
      pop_s  = 1'b0;
    end else begin
      push_s = enq_fire_s;
      pop_s  = deq_fire_s;
    end
  end

  // Next-state for count and pointers; flush overrides any transfer.
  always_comb begin
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (flush_i) begin
      count_nxt_s  = {CNT_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      af_r     <= 1'b0;
    end else begin
      count_r  <= count_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      af_r     <= (count_nxt_s >= AF_C);
    end
  end

  // Storage is intentionally not reset; it is only read while valid.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i) begin
      mem_r[wr_ptr_r] <= enq_data_i;
    end
  end

  assign enq_ready_o   = !full_s;
  assign deq_valid_o   = deq_valid_s;
  assign deq_data_o    = deq_data_s;
  assign count_o       = count_r;
  assign almost_full_o = af_r;

endmodule

// File: tb/tb_vproc_fifo.sv
// Self-checking bench for vproc_fifo (WIDTH=8, DEPTH=3, AF_THRESH=2), with a
// second PASS_THROUGH=1 instance for fall-through behaviour.
module tb_vproc_fifo;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       enq_valid;
  logic [7:0] enq_data;
  logic       deq_ready;
  logic       enq_ready;
  logic       deq_valid;
  logic [7:0] deq_data;
  logic [1:0] count;
  logic       af;

  logic       pt_enq_valid;
  logic [7:0] pt_enq_data;
  logic       pt_deq_ready;
  logic       pt_enq_ready;
  logic       pt_deq_valid;
  logic [7:0] pt_deq_data;
  logic [1:0] pt_count;
  logic       pt_af;

  int total = 0;
  int bad   = 0;
  int mcnt  = 0;
  int n_out = 0;
  logic [7:0] sb_q[$];

  vproc_fifo #(.WIDTH(8), .DEPTH(3), .PASS_THROUGH(0), .AF_THRESH(2)) dut (
    .clk_i(clk), .async_rst_ni(rst_n), .flush_i(flush),
    .enq_ready_o(enq_ready), .enq_valid_i(enq_valid), .enq_data_i(enq_data),
    .deq_ready_i(deq_ready), .deq_valid_o(deq_valid), .deq_data_o(deq_data),
    .count_o(count), .almost_full_o(af)
  );

  vproc_fifo #(.WIDTH(8), .DEPTH(3), .PASS_THROUGH(1), .AF_THRESH(2)) dut_pt (
    .clk_i(clk), .async_rst_ni(rst_n), .flush_i(1'b0),
    .enq_ready_o(pt_enq_ready), .enq_valid_i(pt_enq_valid), .enq_data_i(pt_enq_data),
    .deq_ready_i(pt_deq_ready), .deq_valid_o(pt_deq_valid), .deq_data_o(pt_deq_data),
    .count_o(pt_count), .almost_full_o(pt_af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive inputs, check dequeued word against the scoreboard
  // at mid-cycle, advance the reference model, return at posedge+1.
  task automatic tick(input logic ev, input logic [7:0] ed, input logic dr, input logic fl);
    logic [7:0] exp_d;
    logic acc;
    logic dq;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
    @(negedge clk);
    total++;
    if (deq_valid !== (mcnt != 0)) begin
      bad++;
      $display("FAIL sb_deq_valid: got %b want %b", deq_valid, (mcnt != 0));
    end
    acc = ev && (mcnt < 3);
    dq  = dr && (mcnt > 0);
    if (fl) begin
      sb_q.delete();
      mcnt = 0;
    end else begin
      if (dq) begin
        exp_d = sb_q.pop_front();
        n_out++;
        total++;
        if (deq_data !== exp_d) begin
          bad++;
          $display("FAIL sb_data: got %h want %h", deq_data, exp_d);
        end
      end
      if (acc) sb_q.push_back(ed);
      mcnt = mcnt + (acc ? 1 : 0) - (dq ? 1 : 0);
    end
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (count !== 2'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++;
    if (enq_ready !== 1'b1) begin bad++; $display("FAIL rst_enq_ready: got %b want 1", enq_ready); end
    total++;
    if (deq_valid !== 1'b0) begin bad++; $display("FAIL rst_deq_valid: got %b want 0", deq_valid); end
    total++;
    if (af !== 1'b0) begin bad++; $display("FAIL rst_af: got %b want 0", af); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    total++;
    if (count !== 2'd1 || af !== 1'b0) begin bad++; $display("FAIL fill1: count %0d af %b want 1 0", count, af); end
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    total++;
    if (count !== 2'd2 || af !== 1'b1) begin bad++; $display("FAIL fill2: count %0d af %b want 2 1", count, af); end
    tick(1'b1, 8'h33, 1'b0, 1'b0);
    total++;
    if (count !== 2'd3 || enq_ready !== 1'b0) begin bad++; $display("FAIL fill3: count %0d rdy %b want 3 0", count, enq_ready); end
    tick(1'b1, 8'h44, 1'b0, 1'b0);
    total++;
    if (count !== 2'd3) begin bad++; $display("FAIL fill_refuse: count %0d want 3", count); end
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (count !== 2'd0 || deq_valid !== 1'b0) begin bad++; $display("FAIL fill_drain: count %0d dv %b want 0 0", count, deq_valid); end
  endtask

  task automatic test_full_deq();
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    tick(1'b1, 8'h33, 1'b0, 1'b0);
    tick(1'b1, 8'h44, 1'b1, 1'b0);
    total++;
    if (count !== 2'd2) begin bad++; $display("FAIL full_deq_count: got %0d want 2", count); end
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (count !== 2'd0) begin bad++; $display("FAIL full_deq_drain: got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    int sent;
    int out0;
    logic ev;
    logic dr;
    logic will_acc;
    sent = 0;
    out0 = n_out;
    for (int c = 0; c < 300 && (sent < 10 || mcnt > 0); c++) begin
      ev = (sent < 10) && ($urandom_range(0, 1) == 1);
      dr = ($urandom_range(0, 2) != 0);
      will_acc = ev && (mcnt < 3);
      tick(ev, 8'(sent), dr, 1'b0);
      if (will_acc) sent++;
      total++;
      if (count !== 2'(mcnt) || count > 2'd3) begin bad++; $display("FAIL wrap_count: got %0d want %0d", count, mcnt); end
    end
    total++;
    if ((n_out - out0) != 10 || sent != 10) begin
      bad++;
      $display("FAIL wrap_total: got out=%0d sent=%0d want 10 10", n_out - out0, sent);
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    tick(1'b1, 8'h55, 1'b0, 1'b1);
    total++;
    if (count !== 2'd0 || deq_valid !== 1'b0) begin bad++; $display("FAIL flush: count %0d dv %b want 0 0", count, deq_valid); end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b1, 8'h66, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (count !== 2'd0) begin bad++; $display("FAIL flush_after: count %0d want 0", count); end
  endtask

  task automatic test_pass_through();
    pt_enq_valid = 1'b1;
    pt_enq_data  = 8'hA5;
    pt_deq_ready = 1'b1;
    #2;
    total++;
    if (pt_deq_valid !== 1'b1 || pt_deq_data !== 8'hA5) begin
      bad++;
      $display("FAIL pt_bypass: dv %b data %h want 1 a5", pt_deq_valid, pt_deq_data);
    end
    @(posedge clk);
    #1;
    total++;
    if (pt_count !== 2'd0) begin bad++; $display("FAIL pt_count0: got %0d want 0", pt_count); end
    pt_enq_data  = 8'hB6;
    pt_deq_ready = 1'b0;
    @(posedge clk);
    #1;
    pt_enq_valid = 1'b0;
    total++;
    if (pt_count !== 2'd1) begin bad++; $display("FAIL pt_store: got %0d want 1", pt_count); end
    pt_deq_ready = 1'b1;
    #2;
    total++;
    if (pt_deq_valid !== 1'b1 || pt_deq_data !== 8'hB6) begin
      bad++;
      $display("FAIL pt_stored_out: dv %b data %h want 1 b6", pt_deq_valid, pt_deq_data);
    end
    @(posedge clk);
    #1;
    pt_deq_ready = 1'b0;
    total++;
    if (pt_count !== 2'd0 || pt_deq_valid !== 1'b0) begin
      bad++;
      $display("FAIL pt_drain: count %0d dv %b want 0 0", pt_count, pt_deq_valid);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (count !== 2'd0 || deq_valid !== 1'b0) begin bad++; $display("FAIL rst_mid: count %0d dv %b want 0 0", count, deq_valid); end
    sb_q.delete();
    mcnt = 0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (count !== 2'd0) begin bad++; $display("FAIL rst_mid_after: count %0d want 0", count); end
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    enq_valid    = 1'b0;
    enq_data     = 8'h00;
    deq_ready    = 1'b0;
    pt_enq_valid = 1'b0;
    pt_enq_data  = 8'h00;
    pt_deq_ready = 1'b0;
    test_reset();
    test_fill();
    test_full_deq();
    test_wrap();
    test_flush();
    test_pass_through();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vproc_fifo.md
VPROC_FIFO -- requirements
Module: vproc_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, >= 1.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries, >= 2, not required to be a power of two.
REQ-003 SHALL have parameter PASS_THROUGH, default 0: 1 selects zero-latency fall-through when empty.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-1: almost-full threshold, 1..DEPTH.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port async_rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port flush_i, input, 1 bit: synchronous clear of all contents.
REQ-008 SHALL have port enq_ready_o, output, 1 bit: an entry can be accepted.
REQ-009 SHALL have port enq_valid_i, input, 1 bit: enq_data_i is valid.
REQ-010 SHALL have port enq_data_i, input, WIDTH bits: word to enqueue.
REQ-011 SHALL have port deq_ready_i, input, 1 bit: consumer accepts deq_data_o.
REQ-012 SHALL have port deq_valid_o, output, 1 bit: deq_data_o is valid.
REQ-013 SHALL have port deq_data_o, output, WIDTH bits: oldest word.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH+1) bits: current number of stored entries.
REQ-015 SHALL have port almost_full_o, output, 1 bit: count_o >= AF_THRESH.

Function
REQ-016 SHALL transfer on enq when enq_valid_i & enq_ready_o, and on deq when deq_valid_o & deq_ready_i, both sampled at the rising edge of clk_i.
REQ-017 SHALL drive enq_ready_o = (count_o != DEPTH), from registered state only, with no combinational path from deq_ready_i.
REQ-018 SHALL, with PASS_THROUGH=0, drive deq_valid_o = (count_o != 0) and deq_data_o = entry at read pointer; one-cycle minimum enq-to-deq latency.
REQ-019 SHALL, with PASS_THROUGH=1 and count_o==0, drive deq_valid_o = enq_valid_i and deq_data_o = enq_data_i combinationally; if deq_ready_i is also high, the word is consumed and neither stored nor counted.
REQ-020 SHALL keep read and write pointers in range 0..DEPTH-1, wrapping from DEPTH-1 to 0 independently of power-of-two DEPTH.
REQ-021 SHALL, on simultaneous enq and deq with 0 < count_o < DEPTH, advance both pointers and leave count_o unchanged.
REQ-022 SHALL, when full, refuse enq even if a deq occurs in the same cycle; count_o decrements by 1.
REQ-023 SHALL, when empty with PASS_THROUGH=0, assert no deq; a same-cycle enq makes count_o 1 next cycle.
REQ-024 SHALL, on flush_i=1, zero both pointers and count_o at the next edge; flush has priority over same-cycle enq and deq, and words presented in that cycle are discarded.
REQ-025 SHALL, during a flush_i=1 cycle, still drive handshake outputs from current state; consumers ignore them.
REQ-026 SHALL hold deq_data_o stable while deq_valid_o=1 and deq_ready_i=0 (stored path).
REQ-027 SHALL update almost_full_o from the registered count, one cycle after the causing transfer.
REQ-028 SHALL write storage only on an accepted enq that is not absorbed by pass-through.

Reset
REQ-029 SHALL, on async_rst_ni=0, immediately clear pointers and count: count_o=0, enq_ready_o=1, deq_valid_o=0 (PASS_THROUGH=0) or enq_valid_i (PASS_THROUGH=1), almost_full_o=0.
REQ-030 SHALL leave storage contents unreset; deq_data_o is don't-care while deq_valid_o=0.
REQ-031 SHALL, on reset asserted mid-operation, discard all entries; the first post-reset deq returns the first post-reset enq.

Structure
REQ-032 SHALL need no shared-package typedefs; count and pointer widths derive locally from DEPTH.
REQ-033 SHALL be a single module with storage as an inline register array; no sub-module.
REQ-034 SHALL reject illegal parameters (DEPTH<2, AF_THRESH outside 1..DEPTH) by elaboration-time assertion.

Verification (WIDTH=8, DEPTH=3, AF_THRESH=2 unless stated)
REQ-035 SHALL cover fill: enq 0x11,0x22,0x33 with deq_ready_i=0 -> count_o 1,2,3, almost_full_o at count 2, enq_ready_o=0 at 3, 0x44 refused.
REQ-036 SHALL cover wrap: 10 words 0x00..0x09 with random valid/ready -> output order 0x00..0x09, pointers wrap past 2, count never >3.
REQ-037 SHALL cover full with simultaneous deq: full, enq_valid_i=1, deq_ready_i=1 -> 0x11 out, enq not accepted, count_o=2.
REQ-038 SHALL cover flush: count 2, flush_i=1 with enq 0x55 -> count_o=0 next cycle, deq_valid_o=0, 0x55 never output.
REQ-039 SHALL cover PASS_THROUGH=1: empty, enq 0xA5 with deq_ready_i=1 -> deq_data_o=0xA5 same cycle, count_o stays 0.
REQ-040 SHALL cover reset mid-operation: count 2, async_rst_ni pulsed low -> count_o=0 immediately, next enq 0x77 is the next word out.
